// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: opcode/state encodings, flag indices and the saturating-add helper.
// Build option: ALU_PIPE_MUL_EN adds the MUL opcode sequencer states.
`default_nettype none

package alu_pipe_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_XOR    = 4'd2,
    OP_RED    = 4'd3,
    OP_SLL    = 4'd4,
    OP_SRA    = 4'd5,
    OP_ROR    = 4'd6,
    OP_PADDSB = 4'd7,
    OP_MUL    = 4'd8
  } alu_op_t;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

`ifdef ALU_PIPE_MUL_EN
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_RUN  = 2'd1,
    ST_MUL_DONE = 2'd2
  } alu_state_t;
`else
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0
  } alu_state_t;
`endif

  // Operands arrive sign-extended to 64 bits; the sum is clamped to the signed range of w bits.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    logic signed [63:0] s, hi, lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_pipe_lane_sat.sv
// alu_pipe_lane_sat: W-bit signed saturating add/subtract of one lane.
`default_nettype none

module alu_pipe_lane_sat
  import alu_pipe_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_o
);

  logic signed [63:0] w_a;
  logic signed [63:0] w_b;

  assign w_a   = {{(64-W){a_i[W-1]}}, a_i};
  assign w_b   = sub_i ? -{{(64-W){b_i[W-1]}}, b_i} : {{(64-W){b_i[W-1]}}, b_i};
  assign sum_o = W'(sat_add(w_a, w_b, W));

endmodule

`default_nettype wire

// File: rtl/alu_pipe.sv
// alu_pipe: registered valid/ready ALU with persistent {Z,V,N} flags.
// Build option: ALU_PIPE_MUL_EN enables opcode 1000 (iterative signed multiply).
`default_nettype none

module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int LANE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flags
);

  localparam int SH_W   = $clog2(WIDTH);
  localparam int N_LANE = WIDTH / LANE_W;
  localparam int N_BYTE = WIDTH / 8;

  logic             w_accept, w_consume, w_start_mul;
  logic [SH_W-1:0]  w_sh;
  logic [WIDTH-1:0] w_addsub, w_wrap, w_padd, w_red, w_ror, w_alu_res;
  logic [2:0]       w_alu_flags;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [2:0]       flags_q, flags_d;

  assign w_accept  = in_valid && in_ready;
  assign w_consume = out_valid_q && out_ready;
  assign w_sh      = B[SH_W-1:0];
  assign w_ror     = WIDTH'({A, A} >> w_sh);
  // Saturation happened exactly when the clamped sum differs from the wrapped one.
  assign w_wrap    = (opcode == OP_SUB) ? (A - B) : (A + B);

  alu_pipe_lane_sat #(.W(WIDTH)) u_addsub (
    .a_i  (A),
    .b_i  (B),
    .sub_i(opcode == OP_SUB),
    .sum_o(w_addsub)
  );

  for (genvar g = 0; g < N_LANE; g++) begin : g_lane
    alu_pipe_lane_sat #(.W(LANE_W)) u_lane (
      .a_i  (A[g*LANE_W +: LANE_W]),
      .b_i  (B[g*LANE_W +: LANE_W]),
      .sub_i(1'b0),
      .sum_o(w_padd[g*LANE_W +: LANE_W])
    );
  end

  always_comb begin
    w_red = '0;
    for (int i = 0; i < N_BYTE; i++) begin
      w_red = w_red + WIDTH'($signed(A[8*i +: 8])) + WIDTH'($signed(B[8*i +: 8]));
    end
  end

  always_comb begin
    w_alu_res   = '0;
    w_alu_flags = flags_q;
    case (opcode)
      OP_ADD, OP_SUB: begin
        w_alu_res           = w_addsub;
        w_alu_flags[FLAG_Z] = ~|w_addsub;
        w_alu_flags[FLAG_V] = (w_addsub != w_wrap);
        w_alu_flags[FLAG_N] = w_addsub[WIDTH-1];
      end
      OP_XOR: begin
        w_alu_res           = A ^ B;
        w_alu_flags[FLAG_Z] = ~|(A ^ B);
      end
      OP_RED:    w_alu_res = w_red;
      OP_SLL: begin
        w_alu_res           = A << w_sh;
        w_alu_flags[FLAG_Z] = ~|(A << w_sh);
      end
      OP_SRA: begin
        w_alu_res           = $signed(A) >>> w_sh;
        w_alu_flags[FLAG_Z] = ~|($signed(A) >>> w_sh);
      end
      OP_ROR: begin
        w_alu_res           = w_ror;
        w_alu_flags[FLAG_Z] = ~|w_ror;
      end
      OP_PADDSB: w_alu_res = w_padd;
      default:   w_alu_res = '0;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  alu_state_t         state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, w_prod;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               neg_q, neg_d;
  logic [SH_W:0]      cnt_q, cnt_d;

  assign w_start_mul = w_accept && (opcode == OP_MUL);
  assign in_ready    = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  // Magnitudes are multiplied unsigned; the sign is reapplied to the full product.
  assign w_prod      = neg_q ? -acc_q : acc_q;
`else
  assign w_start_mul = 1'b0;
  assign in_ready    = !out_valid_q || out_ready;
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    if (w_consume) out_valid_d = 1'b0;
    if (w_accept && !w_start_mul) begin
      out_valid_d = 1'b1;
      result_d    = w_alu_res;
      flags_d     = w_alu_flags;
    end
`ifdef ALU_PIPE_MUL_EN
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_start_mul) begin
          state_d  = ST_MUL_RUN;
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, (A[WIDTH-1] ? -A : A)};
          mplier_d = B[WIDTH-1] ? -B : B;
          neg_d    = A[WIDTH-1] ^ B[WIDTH-1];
          cnt_d    = '0;
        end
      end
      ST_MUL_RUN: begin
        if (cnt_q == (SH_W+1)'(WIDTH)) begin
          state_d         = ST_MUL_DONE;
          out_valid_d     = 1'b1;
          result_d        = w_prod[WIDTH-1:0];
          flags_d[FLAG_Z] = ~|w_prod[WIDTH-1:0];
          flags_d[FLAG_V] = !((&w_prod[2*WIDTH-1:WIDTH-1]) || (~|w_prod[2*WIDTH-1:WIDTH-1]));
          flags_d[FLAG_N] = w_prod[WIDTH-1];
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      ST_MUL_DONE: if (w_consume) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= 3'b000;
`ifdef ALU_PIPE_MUL_EN
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      neg_q       <= 1'b0;
      cnt_q       <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
`ifdef ALU_PIPE_MUL_EN
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      neg_q       <= neg_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed corner cases plus randomized handshake traffic against a reference model.
`default_nettype none

module tb_alu_pipe;

  localparam int W   = 16;
  localparam int LW  = 4;
  localparam int SHW = $clog2(W);
  localparam longint MAXV = (longint'(1) << (W - 1)) - 1;
  localparam longint MINV = -MAXV - 1;
  localparam int LMAX = (1 << (LW - 1)) - 1;
  localparam int LMIN = -LMAX - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [3:0]   opcode = 4'd0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] result;
  logic [2:0]   flags;

  int total = 0;
  int bad = 0;
  logic [2:0] m_flags = 3'b000;

  typedef struct {
    logic [W-1:0] r;
    logic [2:0]   f;
  } exp_t;

  alu_pipe #(.WIDTH(W), .LANE_W(LW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .opcode   (opcode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flags    (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference behaviour expressed with integer arithmetic; flags are {Z,V,N}.
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] f, output logic [W-1:0] r, output logic [2:0] nf);
    longint sa, sb, s;
    int sh, x;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[SHW-1:0]);
    r  = '0;
    nf = f;
    case (op)
      4'd0, 4'd1: begin
        s = (op == 4'd0) ? sa + sb : sa - sb;
        nf[1] = (s > MAXV) || (s < MINV);
        if (s > MAXV) s = MAXV;
        if (s < MINV) s = MINV;
        r = s[W-1:0];
        nf[2] = (s == 0);
        nf[0] = (s < 0);
      end
      4'd2: begin r = a ^ b; nf[2] = (r == 0); end
      4'd3: begin
        s = 0;
        for (int i = 0; i < W / 8; i++)
          s = s + longint'($signed(a[8*i +: 8])) + longint'($signed(b[8*i +: 8]));
        r = s[W-1:0];
      end
      4'd4: begin s = longint'(a) * (longint'(1) << sh); r = s[W-1:0]; nf[2] = (r == 0); end
      4'd5: begin
        s = sa;
        for (int k = 0; k < sh; k++) s = (s - (s & 1)) / 2;
        r = s[W-1:0];
        nf[2] = (r == 0);
      end
      4'd6: begin
        r = a;
        for (int k = 0; k < sh; k++) r = {r[0], r[W-1:1]};
        nf[2] = (r == 0);
      end
      4'd7: begin
        for (int l = 0; l < W / LW; l++) begin
          x = int'($signed(a[l*LW +: LW])) + int'($signed(b[l*LW +: LW]));
          if (x > LMAX) x = LMAX;
          if (x < LMIN) x = LMIN;
          r[l*LW +: LW] = x[LW-1:0];
        end
      end
      default: r = '0;
    endcase
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return {1'b0, {(W-1){1'b1}}};
      2: return {1'b1, {(W-1){1'b0}}};
      3: return '1;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    logic [W-1:0] er;
    logic [2:0]   ef;
    int n;
    model(op, a, b, m_flags, er, ef);
    m_flags = ef;
    @(posedge clk); #1;
    opcode = op; A = a; B = b; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check({tag, " accept"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, " valid"}, out_valid, 1);
    check({tag, " res"}, result, er);
    check({tag, " flags"}, flags, ef);
  endtask

  initial begin
    exp_t q[$];
    exp_t e;
    logic [W-1:0] er;
    logic [2:0]   ef;
    int acc_cnt, cyc, n;

    repeat (2) @(negedge clk);
    check("rst out_valid", out_valid, 0);
    check("rst result", result, 0);
    check("rst flags", flags, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst in_ready", in_ready, 1);

    do_op("add_hi", 4'd0, 16'h7FFF, 16'h0001);
    check("add_hi const", result, 16'h7FFF);
    check("add_hi fconst", flags, 3'b010);
    do_op("add_lo", 4'd0, 16'h8000, 16'hFFFF);
    check("add_lo const", result, 16'h8000);
    check("add_lo fconst", flags, 3'b011);
    do_op("paddsb", 4'd7, 16'h7878, 16'h1818);
    check("paddsb const", result, 16'h7878);
    do_op("ror", 4'd6, 16'h3BCA, 16'd5);
    check("ror const", result, 16'h51DE);
    do_op("sra", 4'd5, 16'h8000, 16'd15);
    check("sra const", result, 16'hFFFF);
    do_op("sll", 4'd4, 16'h0001, 16'd15);
    check("sll const", result, 16'h8000);
    check("sll z", flags[2], 0);
    do_op("sub_lo", 4'd1, 16'h8000, 16'h0001);
    check("sub_lo const", result, 16'h8000);
    do_op("xor_z", 4'd2, 16'h5555, 16'h5555);
    check("xor_z fconst", flags, 3'b111);
    do_op("add_small", 4'd0, 16'h0001, 16'h0001);
    do_op("red", 4'd3, 16'hFF01, 16'h8080);
    check("red const", result, 16'hFF00);
    check("red fconst", flags, 3'b000);
    do_op("rsvd", 4'd15, 16'h1234, 16'h5678);
    do_op("ror0", 4'd6, 16'hA5C3, 16'h0010);
    check("ror0 const", result, 16'hA5C3);

    // Back-pressure: ADD result held while an XOR waits.
    do_op("bp_add", 4'd0, 16'h7FFF, 16'h0001);
    out_ready = 1'b0;
    opcode = 4'd2; A = 16'h1234; B = 16'h00FF; in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("bp in_ready", in_ready, 0);
      check("bp result", result, 16'h7FFF);
      check("bp flags", flags, 3'b010);
    end
    out_ready = 1'b1;
    #1;
    check("bp ready up", in_ready, 1);
    model(4'd2, 16'h1234, 16'h00FF, m_flags, er, ef);
    m_flags = ef;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp xor res", result, er);
    check("bp xor const", result, 16'h12CB);
    check("bp xor flags", flags, ef);

    // Asynchronous reset with a pending result.
    do_op("mr_add", 4'd0, 16'h8000, 16'hFFFF);
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mr out_valid", out_valid, 0);
    check("mr result", result, 0);
    check("mr flags", flags, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_flags = 3'b000;
    @(posedge clk); #1;
    check("mr in_ready", in_ready, 1);

    // Randomized traffic with random back-pressure; scoreboard holds outstanding results.
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    acc_cnt = 0;
    cyc = 0;
    while (acc_cnt < 150 && cyc < 3000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      opcode    = 4'($urandom_range(0, 15));
`ifdef ALU_PIPE_MUL_EN
      if (opcode == 4'd8) opcode = 4'd9;
`endif
      A         = pick();
      B         = pick();
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      check("rnd in_ready", in_ready, (q.size() == 0) || out_ready);
      check("rnd out_valid", out_valid, q.size() != 0);
      if (out_valid && out_ready && q.size() != 0) begin
        e = q.pop_front();
        check("rnd res", result, e.r);
        check("rnd flags", flags, e.f);
      end
      if (in_valid && in_ready) begin
        model(opcode, A, B, m_flags, er, ef);
        m_flags = ef;
        e.r = er;
        e.f = ef;
        q.push_back(e);
        acc_cnt++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("rnd accepted", acc_cnt, 150);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    if (out_valid && q.size() != 0) begin
      e = q.pop_front();
      check("drain res", result, e.r);
      check("drain flags", flags, e.f);
    end
    @(posedge clk);
    @(negedge clk);
    check("drain empty", out_valid, 0);
    check("drain queue", q.size(), 0);

`ifdef ALU_PIPE_MUL_EN
    @(posedge clk); #1;
    opcode = 4'd8; A = 16'd3; B = 16'hFFFE; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("mul accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mul busy", in_ready, 0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mulrst out_valid", out_valid, 0);
    check("mulrst flags", flags, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_flags = 3'b000;
    #1;
    check("mulrst in_ready", in_ready, 1);
    @(posedge clk); #1;
    opcode = 4'd8; A = 16'd3; B = 16'hFFFE; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("mul latency", n, W + 1);
    check("mul res", result, 16'hFFFA);
    check("mul flags", flags, 3'b001);
    m_flags = 3'b001;
    @(negedge clk);
    check("mul hold ready", in_ready, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
